// File: rtl/redmule_mx_lane_decoder.sv
// redmule_mx_lane_decoder
// Joins one MX value word (DATA_W/8 FP8 elements) with its shared E8M0 scale,
// then drains the block as NUM_LANES FP16 values per beat. E4M3 or E5M2 is
// selected per block. The conversion is exact, so no rounding logic is needed.
module redmule_mx_lane_decoder #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned BITW      = 16,
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        mx_val_valid_i,
  output logic                        mx_val_ready_o,
  input  logic [DATA_W-1:0]           mx_val_data_i,
  input  logic                        mx_exp_valid_i,
  output logic                        mx_exp_ready_o,
  input  logic [7:0]                  mx_exp_data_i,
  input  logic                        fmt_i,
  output logic                        fp16_valid_o,
  input  logic                        fp16_ready_i,
  output logic [NUM_LANES*BITW-1:0]   fp16_data_o,
  output logic                        fp16_last_o
);

  localparam int unsigned NUM_ELEMS = DATA_W / 8;
  localparam int unsigned NUM_BEATS = NUM_ELEMS / NUM_LANES;
  localparam int unsigned CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned BEAT_W    = NUM_LANES * 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Exact FP8 (E4M3/E5M2) times 2^(scale-127) to FP16; overflow saturates to
  // Inf and underflow flushes to signed zero.
  function automatic logic [15:0] mx_to_fp16(input logic [7:0] elem,
                                             input logic       fmt,
                                             input logic [7:0] scale);
    logic               sign;
    logic [4:0]         e8;
    logic [9:0]         mant;
    logic [9:0]         mant_n;
    logic [1:0]         shamt;
    logic               is_nan;
    logic               is_inf;
    logic               is_zero;
    logic               is_sub;
    logic signed [10:0] bias;
    logic signed [10:0] e_unb;
    logic signed [10:0] e_fp16;
    logic [15:0]        res;
    sign    = elem[7];
    is_zero = (elem[6:0] == 7'h00);
    if (fmt) begin
      e8     = elem[6:2];
      mant   = {elem[1:0], 8'h00};
      bias   = 11'sd15;
      is_nan = (elem[6:2] == 5'd31) && (elem[1:0] != 2'b00);
      is_inf = (elem[6:2] == 5'd31) && (elem[1:0] == 2'b00);
    end else begin
      e8     = {1'b0, elem[6:3]};
      mant   = {elem[2:0], 7'h00};
      bias   = 11'sd7;
      is_nan = (elem[6:0] == 7'h7F);
      is_inf = 1'b0;
    end
    is_sub = (e8 == 5'd0) && !is_zero;
    // Subnormals: shift past the leading one so it becomes the hidden bit.
    casez (mant[9:7])
      3'b1??:  shamt = 2'd1;
      3'b01?:  shamt = 2'd2;
      3'b001:  shamt = 2'd3;
      default: shamt = 2'd1;
    endcase
    if (is_sub) begin
      mant_n = mant << shamt;
      e_unb  = 11'sd1 - bias - $signed({9'd0, shamt});
    end else begin
      mant_n = mant;
      e_unb  = $signed({6'd0, e8}) - bias;
    end
    e_fp16 = e_unb + $signed({3'd0, scale}) - 11'sd127 + 11'sd15;
    if (scale == 8'hFF || is_nan) begin
      res = 16'h7E00;
    end else if (is_inf) begin
      res = {sign, 15'h7C00};
    end else if (is_zero) begin
      res = {sign, 15'h0000};
    end else if (e_fp16 >= 11'sd31) begin
      res = {sign, 15'h7C00};
    end else if (e_fp16 <= 11'sd0) begin
      res = {sign, 15'h0000};
    end else begin
      res = {sign, e_fp16[4:0], mant_n};
    end
    return res;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  val_q, val_d;
  logic [7:0]         exp_q, exp_d;
  logic               fmt_q, fmt_d;
  logic               can_acc_s;
  logic               accept_s;
  logic               hs_s;
  logic               last_hs_s;
  logic [BEAT_W-1:0]  beat_s;

  // Handshake decode: a block is taken only when both halves are present.
  always_comb begin
    hs_s           = fp16_valid_o & fp16_ready_i;
    last_hs_s      = hs_s & (cnt_q == LAST_BEAT);
    can_acc_s      = rst_ni & ((state_q == IDLE) | ((state_q == DRAIN) & last_hs_s));
    accept_s       = can_acc_s & mx_val_valid_i & mx_exp_valid_i;
    mx_val_ready_o = can_acc_s & mx_exp_valid_i;
    mx_exp_ready_o = can_acc_s & mx_val_valid_i;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a last-beat handshake with a new accept stays in DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) state_d = DRAIN;
        else          state_d = IDLE;
      end
      DRAIN: begin
        if (last_hs_s && !accept_s) state_d = IDLE;
        else                        state_d = DRAIN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: load on accept, advance the beat counter on handshake.
  always_comb begin
    cnt_d = cnt_q;
    val_d = val_q;
    exp_d = exp_q;
    fmt_d = fmt_q;
    if (accept_s) begin
      cnt_d = '0;
      val_d = mx_val_data_i;
      exp_d = mx_exp_data_i;
      fmt_d = fmt_i;
    end else if (hs_s) begin
      if (cnt_q == LAST_BEAT) cnt_d = '0;
      else                    cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Block and beat-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      val_q <= '0;
      exp_q <= 8'h00;
      fmt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      val_q <= val_d;
      exp_q <= exp_d;
      fmt_q <= fmt_d;
    end
  end

  // Output decode: lane k of beat b converts element b*NUM_LANES+k; data is zero when idle.
  always_comb begin
    fp16_valid_o = (state_q == DRAIN);
    fp16_last_o  = fp16_valid_o & (cnt_q == LAST_BEAT);
    beat_s       = val_q[cnt_q*BEAT_W +: BEAT_W];
    fp16_data_o  = '0;
    if (fp16_valid_o) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        fp16_data_o[BITW*k +: BITW] = mx_to_fp16(beat_s[8*k +: 8], fmt_q, exp_q);
      end
    end else begin
      fp16_data_o = '0;
    end
  end

endmodule

// File: tb/tb_redmule_mx_lane_decoder.sv
// Scoreboard bench for redmule_mx_lane_decoder: the sender pushes hand-computed
// FP16 beats on accept, a negedge monitor pops and compares on every handshake.
module tb_redmule_mx_lane_decoder;
  localparam int DATA_W    = 256;
  localparam int BITW      = 16;
  localparam int NUM_LANES = 4;
  localparam int NUM_ELEMS = DATA_W / 8;
  localparam int NUM_BEATS = NUM_ELEMS / NUM_LANES;
  localparam int OUT_W     = NUM_LANES * BITW;
  localparam int EX_W      = NUM_ELEMS * 16;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              mx_val_valid_i = 1'b0;
  logic              mx_val_ready_o;
  logic [DATA_W-1:0] mx_val_data_i = '0;
  logic              mx_exp_valid_i = 1'b0;
  logic              mx_exp_ready_o;
  logic [7:0]        mx_exp_data_i = 8'h00;
  logic              fmt_i = 1'b0;
  logic              fp16_valid_o;
  logic              fp16_ready_i = 1'b1;
  logic [OUT_W-1:0]  fp16_data_o;
  logic              fp16_last_o;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  logic  stall_mode = 1'b0;

  redmule_mx_lane_decoder #(
    .DATA_W(DATA_W), .BITW(BITW), .NUM_LANES(NUM_LANES)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .mx_val_valid_i(mx_val_valid_i), .mx_val_ready_o(mx_val_ready_o),
    .mx_val_data_i(mx_val_data_i),
    .mx_exp_valid_i(mx_exp_valid_i), .mx_exp_ready_o(mx_exp_ready_o),
    .mx_exp_data_i(mx_exp_data_i), .fmt_i(fmt_i),
    .fp16_valid_o(fp16_valid_o), .fp16_ready_i(fp16_ready_i),
    .fp16_data_o(fp16_data_o), .fp16_last_o(fp16_last_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] rep_v(input logic [7:0] e);
    return {NUM_ELEMS{e}};
  endfunction

  function automatic logic [EX_W-1:0] rep_e(input logic [15:0] h);
    return {NUM_ELEMS{h}};
  endfunction

  // Lane-mapping pattern, E4M3 with scale 127: element i has exponent 6+(i%8),
  // mantissa i/8, negative when i%3==0; value 2^(i%8-1) * (1 + (i/8)/8).
  function automatic logic [DATA_W-1:0] pat_v();
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      v[8*i +: 8] = 8'h30 + 8'(8 * (i % 8)) + 8'(i / 8) + ((i % 3 == 0) ? 8'h80 : 8'h00);
    end
    return v;
  endfunction

  function automatic logic [EX_W-1:0] pat_e();
    logic [EX_W-1:0] e;
    e = '0;
    for (int i = 0; i < NUM_ELEMS; i++) begin
      e[16*i +: 16] = 16'h3800 + 16'(16'h0400 * (i % 8)) + 16'((i / 8) << 7)
                      + ((i % 3 == 0) ? 16'h8000 : 16'h0000);
    end
    return e;
  endfunction

  // Offer a block; on accept push its expected beats; returns the accept cycle.
  task automatic send(input logic [DATA_W-1:0] v, input logic [7:0] x, input logic f,
                      input logic [EX_W-1:0] ex, output int acc_cyc);
    int    t;
    beat_t b;
    mx_val_valid_i = 1'b1;
    mx_exp_valid_i = 1'b1;
    mx_val_data_i  = v;
    mx_exp_data_i  = x;
    fmt_i          = f;
    t = 0;
    @(negedge clk_i);
    while (!(mx_val_ready_o && mx_exp_ready_o) && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no ready, expected ready within 200 cycles");
    end else begin
      for (int bt = 0; bt < NUM_BEATS; bt++) begin
        b.data = ex[bt*OUT_W +: OUT_W];
        b.last = (bt == NUM_BEATS - 1);
        exp_q.push_back(b);
      end
    end
    @(posedge clk_i);
    #1;
    acc_cyc = cyc;
    mx_val_valid_i = 1'b0;
    mx_exp_valid_i = 1'b0;
    mx_val_data_i  = {8{$urandom()}};
    mx_exp_data_i  = 8'($urandom());
    fmt_i          = 1'($urandom());
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || fp16_valid_o) && t < 1000) begin
      @(posedge clk_i);
      #1;
      t++;
    end
    if (t >= 1000) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
  endtask

  task automatic run_uniform(input logic [7:0] e, input logic [7:0] x, input logic f,
                             input logic [15:0] r);
    int a;
    send(rep_v(e), x, f, rep_e(r), a);
    wait_drain();
  endtask

  // Output ready driver: always ready, or 50% random stalls.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      fp16_ready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares each handshaked beat against the scoreboard and checks
  // that stalled beats hold data and last.
  initial begin
    logic  held_v;
    beat_t held;
    beat_t e;
    held_v = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          check("stall_hold_valid", fp16_valid_o, 1'b1);
          check("stall_hold_beat", {fp16_data_o, fp16_last_o}, held);
        end
        held_v = 1'b0;
        if (fp16_valid_o) begin
          if (!fp16_ready_i) begin
            held_v = 1'b1;
            held   = '{fp16_data_o, fp16_last_o};
          end else if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got %h, expected no beat", fp16_data_o);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", fp16_data_o, e.data);
            check("beat_last", fp16_last_o, e.last);
          end
        end else begin
          check("idle_data_zero", {fp16_data_o, fp16_last_o}, 80'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    int a, b, c0;
    // Reset: inputs offered, every output must stay low.
    mx_val_valid_i = 1'b1;
    mx_exp_valid_i = 1'b1;
    mx_val_data_i  = rep_v(8'h38);
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_val_ready", mx_val_ready_o, 1'b0);
    check("rst_exp_ready", mx_exp_ready_o, 1'b0);
    check("rst_valid", fp16_valid_o, 1'b0);
    check("rst_last", fp16_last_o, 1'b0);
    check("rst_data", fp16_data_o, 64'd0);
    mx_val_valid_i = 1'b0;
    mx_exp_valid_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed conversions, uniform blocks.
    run_uniform(8'h38, 8'd127, 1'b0, 16'h3C00);
    run_uniform(8'h3C, 8'd128, 1'b1, 16'h4000);
    run_uniform(8'h80, 8'd128, 1'b1, 16'h8000);
    run_uniform(8'h7E, 8'd135, 1'b0, 16'h7C00);
    run_uniform(8'h08, 8'd117, 1'b0, 16'h0000);
    run_uniform(8'h01, 8'd127, 1'b0, 16'h1800);
    run_uniform(8'h06, 8'd127, 1'b0, 16'h2200);
    run_uniform(8'h03, 8'd137, 1'b1, 16'h2A00);
    run_uniform(8'h38, 8'hFF, 1'b0, 16'h7E00);
    run_uniform(8'h00, 8'hFF, 1'b1, 16'h7E00);
    run_uniform(8'hFF, 8'd127, 1'b0, 16'h7E00);
    run_uniform(8'h7D, 8'd127, 1'b1, 16'h7E00);
    run_uniform(8'h7C, 8'd127, 1'b1, 16'h7C00);
    run_uniform(8'hFC, 8'd10, 1'b1, 16'hFC00);
    run_uniform(8'hFB, 8'd140, 1'b1, 16'hFC00);
    run_uniform(8'h00, 8'd200, 1'b0, 16'h0000);
    run_uniform(8'h80, 8'd250, 1'b1, 16'h8000);

    // Lane mapping.
    send(pat_v(), 8'd127, 1'b0, pat_e(), a);
    wait_drain();

    // Back-to-back: second block accepted on the last-beat cycle, no bubble.
    send(rep_v(8'h38), 8'd127, 1'b0, rep_e(16'h3C00), a);
    send(pat_v(), 8'd127, 1'b0, pat_e(), b);
    check("b2b_accept_cycle", 80'(b - a), 80'(NUM_BEATS));
    @(negedge clk_i);
    check("b2b_no_bubble", fp16_valid_o, 1'b1);
    wait_drain();

    // Random output stalls.
    stall_mode = 1'b1;
    send(pat_v(), 8'd127, 1'b0, pat_e(), a);
    send(rep_v(8'h3C), 8'd128, 1'b1, rep_e(16'h4000), b);
    send(rep_v(8'h01), 8'd127, 1'b0, rep_e(16'h1800), b);
    wait_drain();
    stall_mode = 1'b0;
    @(posedge clk_i);
    #1;

    // Join: a lone value word never consumes.
    mx_val_valid_i = 1'b1;
    mx_val_data_i  = rep_v(8'h48);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check("join_val_ready_low", mx_val_ready_o, 1'b0);
      check("join_no_output", fp16_valid_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    mx_val_valid_i = 1'b0;
    mx_exp_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("join_exp_ready_low", mx_exp_ready_o, 1'b0);
    end
    @(posedge clk_i);
    #1;
    c0 = cyc;
    send(rep_v(8'h48), 8'd127, 1'b0, rep_e(16'h4400), a);
    check("join_accept_cycle", 80'(a - c0), 80'd1);
    check("join_first_beat_valid", fp16_valid_o, 1'b1);
    wait_drain();

    // Mid-block reset at beat 3.
    send(pat_v(), 8'd127, 1'b0, pat_e(), a);
    c0 = 0;
    while (exp_q.size() > NUM_BEATS - 3 && c0 < 100) begin
      @(posedge clk_i);
      #1;
      c0++;
    end
    check("reset_reached_beat3", dut.cnt_q, 3'd3);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", fp16_valid_o, 1'b0);
    check("midrst_last", fp16_last_o, 1'b0);
    check("midrst_data", fp16_data_o, 64'd0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("postrst_no_beats", fp16_valid_o, 1'b0);

    // Recovery after reset.
    run_uniform(8'h38, 8'd127, 1'b0, 16'h3C00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
